fp_operand_aligner: RTL and testbench
=====================================

// Module: fp_operand_aligner
// PURPOSE
// - Upstream stage of the mantissa BigALU: unpacks two IEEE-754 singles into 24-bit mantissas, signs and exponent.
// - Sum: right-shifts the smaller-exponent mantissa one bit per cycle until the exponents match.
// - Mult: computes the biased product exponent; the mantissas pass through unshifted.
// - Feeds valor1/valor2/sumOrMultiplication of the BigALU through a valid/ready handshake.
// PARAMETERS
// - EXP_W   8    exponent field width
// - MANT_W  24   mantissa width including hidden bit
// - BIAS    127  exponent bias
// PORTS
// - clk                  in   1       single clock, rising edge
// - rst_n                in   1       asynchronous, active-low reset
// - in_valid             in   1       op_a/op_b/sum_or_mult valid
// - in_ready             out  1       aligner can accept (1 only in IDLE)
// - op_a, op_b           in   32      packed single-precision operands
// - sum_or_mult          in   1       1 = sum, 0 = multiplication (BigALU polarity)
// - out_valid            out  1       aligned result valid
// - out_ready            in   1       downstream consumes result
// - mant_a, mant_b       out  24      aligned mantissas -> BigALU valor1/valor2
// - exp_out              out  10      signed result exponent (biased)
// - sign_a, sign_b       out  1       operand signs
// - sum_or_mult_out      out  1       registered copy of sum_or_mult
// - zero_a, zero_b       out  1       operand is +/-0 (exp 0, frac 0)
// - special              out  1       either operand exp == 255 (Inf/NaN)
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; in_ready=1; every other output = 0; shift counter = 0.
// - Unpack:
//   - hidden bit = (exp != 0); effective exp = (exp == 0) ? 1 : exp.
//   - mant = {hidden, frac[22:0]}.
// - FSM IDLE -> ALIGN -> DONE -> IDLE.
// - IDLE:
//   - in_valid & in_ready captures the operands and all flags.
//   - If sum & !special & ea != eb: load cnt = min(|ea - eb|, 24), go to ALIGN.
//   - Otherwise go to DONE.
// - ALIGN:
//   - Each cycle shifts the smaller-exponent mantissa right by 1 (zero fill, truncate) and decrements cnt.
//   - When cnt == 1 this cycle, go to DONE.
//   - Lasts exactly min(d, 24) cycles.
// - DONE:
//   - out_valid = 1; all outputs held stable until out_ready = 1.
//   - out_valid & out_ready -> IDLE; in_ready = 1 again in the next cycle.
//   - No back-to-back accept in the same cycle.
// - Exponent:
//   - Sum: exp_out = max(ea, eb).
//   - Mult: exp_out = ea + eb - BIAS, computed sign-extended to 10 bits.
//   - Mult overflow (exp_out > 254) and underflow (exp_out < 1) are visible to the normaliser via the extra bits, never clamped here.
// - Latency from accept to out_valid:
//   - 1 cycle for mult, equal exponents or special.
//   - 1 + min(d, 24) cycles for sum with exponent difference d.
// - Boundaries:
//   - d >= 24: the shifted mantissa becomes 0 after 24 cycles; no longer stall.
//   - zero_x and special bypass shifting; operands go out raw.
//   - in_valid while not in IDLE: ignored (in_ready = 0), no capture.
//   - out_ready held high entering DONE: out_valid lasts exactly 1 cycle.
//   - rst_n asserted mid-ALIGN or mid-DONE: immediate abort to IDLE, outputs cleared, no partial result emitted.
// STRUCTURE
// - Shared package fp_pkg:
//   - EXP_W, MANT_W, BIAS, EXP_SPECIAL = 8'hFF.
//   - State encoding: IDLE = 2'd0, ALIGN = 2'd1, DONE = 2'd2.
// - One sub-module mant_shift_reg:
//   - MANT_W-bit register with load / shift-right-1 / hold.
//   - Asynchronous active-low reset.
//   - Instantiated twice, one per operand.
// - FSM, counter, exponent arithmetic and flags live in the top module.
// TESTING
// - Sum, equal exponents: op_a = 0x3FC00000 (1.5), op_b = 0x3F800000 (1.0).
//   -> out_valid 1 cycle after accept; mant_a = 0xC00000, mant_b = 0x800000, exp_out = 127.
// - Sum, d = 2: op_a = 0x40800000 (4.0), op_b = 0x3F800000 (1.0).
//   -> out_valid 3 cycles after accept; mant_a = 0x800000, mant_b = 0x200000, exp_out = 129.
// - Sum, d = 40: op_a = 0x53800000, op_b = 0x3F800000.
//   -> 25 cycles latency; mant_b = 0, exp_out = 167.
// - Mult: op_a = 0x40400000 (3.0), op_b = 0x40000000 (2.0), sum_or_mult = 0.
//   -> 1 cycle latency; mant_a = 0xC00000, mant_b = 0x800000, exp_out = 129.
//   - Also op_b = 0: zero_b = 1.
// - Backpressure: hold out_ready = 0 for 5 cycles in DONE.
//   -> outputs stable, in_ready = 0, second in_valid ignored.
//   - Release -> IDLE next cycle.
// - Reset mid-ALIGN (d = 10, rst_n low at cycle 4).
//   -> all outputs 0 the same cycle; in_ready = 1 after release; no out_valid.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants, FSM encoding and unpack helpers for the single-precision operand aligner.
package fp_pkg;

    localparam int EXP_W     = 8;
    localparam int MANT_W    = 24;
    localparam int BIAS      = 127;
    localparam int EXP_OUT_W = 10;
    localparam int CNT_W     = 5;

    localparam logic [EXP_W-1:0]  EXP_SPECIAL = 8'hFF;
    localparam logic [EXP_W-1:0]  EXP_ONE     = 8'd1;
    localparam logic [CNT_W-1:0]  MAX_SHIFT   = 5'd24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        DONE  = 2'd2
    } alignState_t;

    // Denormals behave as exponent 1 with the hidden bit cleared.
    function automatic logic [EXP_W-1:0] effExp(input logic [31:0] op);
        return (op[30:23] == 8'd0) ? EXP_ONE : op[30:23];
    endfunction

    function automatic logic [MANT_W-1:0] mantOf(input logic [31:0] op);
        return {(op[30:23] != 8'd0), op[22:0]};
    endfunction

endpackage

// File: rtl/mant_shift_reg.sv
// Mantissa holding register: parallel load, logical shift right by one, or hold.
module mant_shift_reg
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [MANT_W-1:0] din,
    output logic [MANT_W-1:0] q
);

    logic [MANT_W-1:0] mant_r;

    // Load has priority over shift; shifting zero-fills from the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mant_r <= '0;
        end else if (load) begin
            mant_r <= din;
        end else if (shift) begin
            mant_r <= {1'b0, mant_r[MANT_W-1:1]};
        end else begin
            mant_r <= mant_r;
        end
    end

    assign q = mant_r;

endmodule

// File: rtl/fp_operand_aligner.sv
// Unpacks two singles and aligns their mantissas (sum) or forms the product exponent (mult)
// ahead of the mantissa BigALU.
module fp_operand_aligner
    import fp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          op_a,
    input  logic [31:0]          op_b,
    input  logic                 sum_or_mult,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MANT_W-1:0]    mant_a,
    output logic [MANT_W-1:0]    mant_b,
    output logic [EXP_OUT_W-1:0] exp_out,
    output logic                 sign_a,
    output logic                 sign_b,
    output logic                 sum_or_mult_out,
    output logic                 zero_a,
    output logic                 zero_b,
    output logic                 special
);

    alignState_t          state_r, stateNext_s;
    logic [CNT_W-1:0]     cnt_r, cntNext_s;
    logic                 outValid_r, inReady_r;
    logic                 shiftSelA_r;
    logic [EXP_OUT_W-1:0] expOut_r;
    logic                 signA_r, signB_r, sumOrMult_r, zeroA_r, zeroB_r, special_r;

    logic                 loadOps_s, shiftA_s, shiftB_s;
    logic [EXP_W-1:0]     effA_s, effB_s, diff_s;
    logic                 zeroA_s, zeroB_s, special_s, needAlign_s;
    logic [CNT_W-1:0]     alignCnt_s;
    logic [EXP_OUT_W-1:0] expNext_s;

    assign effA_s    = effExp(op_a);
    assign effB_s    = effExp(op_b);
    assign zeroA_s   = (op_a[30:0] == 31'd0);
    assign zeroB_s   = (op_b[30:0] == 31'd0);
    assign special_s = (op_a[30:23] == EXP_SPECIAL) || (op_b[30:23] == EXP_SPECIAL);

    // Operand decode: shift distance and result exponent for whichever operation is requested.
    always_comb begin
        diff_s      = '0;
        alignCnt_s  = '0;
        expNext_s   = '0;
        needAlign_s = 1'b0;
        if (effA_s >= effB_s) begin
            diff_s = effA_s - effB_s;
        end else begin
            diff_s = effB_s - effA_s;
        end
        if (diff_s > 8'd24) begin
            alignCnt_s = MAX_SHIFT;
        end else begin
            alignCnt_s = diff_s[CNT_W-1:0];
        end
        if (sum_or_mult) begin
            expNext_s = (effA_s >= effB_s) ? {2'b00, effA_s} : {2'b00, effB_s};
        end else begin
            // Wraps as two's complement so the normaliser sees overflow and underflow.
            expNext_s = {2'b00, effA_s} + {2'b00, effB_s} - EXP_OUT_W'(BIAS);
        end
        needAlign_s = sum_or_mult && !special_s && !zeroA_s && !zeroB_s && (diff_s != 8'd0);
    end

    // Next-state, shift counter and shift-register control.
    always_comb begin
        stateNext_s = state_r;
        cntNext_s   = cnt_r;
        loadOps_s   = 1'b0;
        shiftA_s    = 1'b0;
        shiftB_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid && inReady_r) begin
                    loadOps_s = 1'b1;
                    if (needAlign_s) begin
                        stateNext_s = ALIGN;
                        cntNext_s   = alignCnt_s;
                    end else begin
                        stateNext_s = DONE;
                    end
                end else begin
                    stateNext_s = IDLE;
                end
            end
            ALIGN: begin
                shiftA_s  = shiftSelA_r;
                shiftB_s  = !shiftSelA_r;
                cntNext_s = cnt_r - 5'd1;
                if (cnt_r == 5'd1) begin
                    stateNext_s = DONE;
                end else begin
                    stateNext_s = ALIGN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    stateNext_s = IDLE;
                end else begin
                    stateNext_s = DONE;
                end
            end
            default: begin
                stateNext_s = IDLE;
                cntNext_s   = '0;
            end
        endcase
    end

    // State, counter, handshake flags and captured operand attributes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            outValid_r  <= 1'b0;
            inReady_r   <= 1'b1;
            shiftSelA_r <= 1'b0;
            expOut_r    <= '0;
            signA_r     <= 1'b0;
            signB_r     <= 1'b0;
            sumOrMult_r <= 1'b0;
            zeroA_r     <= 1'b0;
            zeroB_r     <= 1'b0;
            special_r   <= 1'b0;
        end else begin
            state_r    <= stateNext_s;
            cnt_r      <= cntNext_s;
            outValid_r <= (stateNext_s == DONE);
            inReady_r  <= (stateNext_s == IDLE);
            if (loadOps_s) begin
                shiftSelA_r <= (effA_s < effB_s);
                expOut_r    <= expNext_s;
                signA_r     <= op_a[31];
                signB_r     <= op_b[31];
                sumOrMult_r <= sum_or_mult;
                zeroA_r     <= zeroA_s;
                zeroB_r     <= zeroB_s;
                special_r   <= special_s;
            end
        end
    end

    mant_shift_reg uMantA (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (loadOps_s),
        .shift (shiftA_s),
        .din   (mantOf(op_a)),
        .q     (mant_a)
    );

    mant_shift_reg uMantB (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (loadOps_s),
        .shift (shiftB_s),
        .din   (mantOf(op_b)),
        .q     (mant_b)
    );

    assign in_ready        = inReady_r;
    assign out_valid       = outValid_r;
    assign exp_out         = expOut_r;
    assign sign_a          = signA_r;
    assign sign_b          = signB_r;
    assign sum_or_mult_out = sumOrMult_r;
    assign zero_a          = zeroA_r;
    assign zero_b          = zeroB_r;
    assign special         = special_r;

endmodule

// File: tb/tb_fp_operand_aligner.sv
// Directed-vector bench for fp_operand_aligner with hand-computed expectations.
module tb_fp_operand_aligner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, sum_or_mult, out_valid, out_ready;
    logic [31:0] op_a, op_b;
    logic [23:0] mant_a, mant_b;
    logic [9:0]  exp_out;
    logic        sign_a, sign_b, sum_or_mult_out, zero_a, zero_b, special;

    int testCount = 0;
    int failCount = 0;
    int lat;
    int hits;

    fp_operand_aligner dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .op_a            (op_a),
        .op_b            (op_b),
        .sum_or_mult     (sum_or_mult),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .mant_a          (mant_a),
        .mant_b          (mant_b),
        .exp_out         (exp_out),
        .sign_a          (sign_a),
        .sign_b          (sign_b),
        .sum_or_mult_out (sum_or_mult_out),
        .zero_a          (zero_a),
        .zero_b          (zero_b),
        .special         (special)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] expVal);
        testCount++;
        if (got !== expVal) begin
            failCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expVal);
        end
    endtask

    // Present one operation for one accept edge, then count edges until out_valid.
    task automatic sendOp(input logic [31:0] a, input logic [31:0] b, input logic som,
                          output int latOut);
        op_a        = a;
        op_b        = b;
        sum_or_mult = som;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        latOut   = 1;
        while (!out_valid && latOut < 60) begin
            @(posedge clk);
            #1;
            latOut++;
        end
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkVal({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        checkVal({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        op_a        = 32'd0;
        op_b        = 32'd0;
        sum_or_mult = 1'b0;
        #12;
        checkVal("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkVal("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkVal("rst_mant_a", {8'd0, mant_a}, 32'd0);
        checkVal("rst_exp", {22'd0, exp_out}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Sum, equal exponents
        sendOp(32'h3FC00000, 32'h3F800000, 1'b1, lat);
        checkVal("eq_lat", lat, 32'd1);
        checkVal("eq_mant_a", {8'd0, mant_a}, 32'hC00000);
        checkVal("eq_mant_b", {8'd0, mant_b}, 32'h800000);
        checkVal("eq_exp", {22'd0, exp_out}, 32'd127);
        checkVal("eq_som", {31'd0, sum_or_mult_out}, 32'd1);
        consume("eq");

        // Sum, d = 2
        sendOp(32'h40800000, 32'h3F800000, 1'b1, lat);
        checkVal("d2_lat", lat, 32'd3);
        checkVal("d2_mant_a", {8'd0, mant_a}, 32'h800000);
        checkVal("d2_mant_b", {8'd0, mant_b}, 32'h200000);
        checkVal("d2_exp", {22'd0, exp_out}, 32'd129);
        consume("d2");

        // Sum, smaller operand first, d = 2: mant_a must be the one shifted
        sendOp(32'h3F800000, 32'h40800000, 1'b1, lat);
        checkVal("d2r_lat", lat, 32'd3);
        checkVal("d2r_mant_a", {8'd0, mant_a}, 32'h200000);
        checkVal("d2r_mant_b", {8'd0, mant_b}, 32'h800000);
        consume("d2r");

        // Sum, d = 40 saturates at 24 shifts
        sendOp(32'h53800000, 32'h3F800000, 1'b1, lat);
        checkVal("d40_lat", lat, 32'd25);
        checkVal("d40_mant_b", {8'd0, mant_b}, 32'd0);
        checkVal("d40_mant_a", {8'd0, mant_a}, 32'h800000);
        checkVal("d40_exp", {22'd0, exp_out}, 32'd167);
        consume("d40");

        // Multiplication
        sendOp(32'h40400000, 32'h40000000, 1'b0, lat);
        checkVal("mul_lat", lat, 32'd1);
        checkVal("mul_mant_a", {8'd0, mant_a}, 32'hC00000);
        checkVal("mul_mant_b", {8'd0, mant_b}, 32'h800000);
        checkVal("mul_exp", {22'd0, exp_out}, 32'd129);
        checkVal("mul_som", {31'd0, sum_or_mult_out}, 32'd0);
        consume("mul");

        // Multiplication by zero with out_ready already high: one-cycle valid
        out_ready = 1'b1;
        sendOp(32'h40400000, 32'h00000000, 1'b0, lat);
        checkVal("mz_lat", lat, 32'd1);
        checkVal("mz_zero_b", {31'd0, zero_b}, 32'd1);
        checkVal("mz_zero_a", {31'd0, zero_a}, 32'd0);
        checkVal("mz_exp", {22'd0, exp_out}, 32'd2);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkVal("mz_one_cycle", {31'd0, out_valid}, 32'd0);
        checkVal("mz_ready", {31'd0, in_ready}, 32'd1);

        // Multiplication underflow shows up as a negative 10-bit exponent
        sendOp(32'h00800000, 32'h00800000, 1'b0, lat);
        checkVal("uf_exp", {22'd0, exp_out}, 32'h383);
        consume("uf");

        // Special and negative-sign operand bypass shifting
        sendOp(32'hFF800000, 32'h3F800000, 1'b1, lat);
        checkVal("sp_lat", lat, 32'd1);
        checkVal("sp_flag", {31'd0, special}, 32'd1);
        checkVal("sp_sign_a", {31'd0, sign_a}, 32'd1);
        checkVal("sp_mant_b", {8'd0, mant_b}, 32'h800000);
        checkVal("sp_exp", {22'd0, exp_out}, 32'd255);
        consume("sp");

        // Zero operand in a sum: no alignment stall
        sendOp(32'h00000000, 32'h3F800000, 1'b1, lat);
        checkVal("z_lat", lat, 32'd1);
        checkVal("z_zero_a", {31'd0, zero_a}, 32'd1);
        checkVal("z_exp", {22'd0, exp_out}, 32'd127);
        consume("z");

        // Denormal vs smallest normal: both effective exponent 1
        sendOp(32'h00400000, 32'h00800000, 1'b1, lat);
        checkVal("dn_lat", lat, 32'd1);
        checkVal("dn_mant_a", {8'd0, mant_a}, 32'h400000);
        checkVal("dn_exp", {22'd0, exp_out}, 32'd1);
        consume("dn");

        // Backpressure: held result, ignored second request
        sendOp(32'h3FC00000, 32'h3F800000, 1'b1, lat);
        op_a     = 32'h40400000;
        op_b     = 32'h40000000;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkVal("bp_valid", {31'd0, out_valid}, 32'd1);
            checkVal("bp_in_ready", {31'd0, in_ready}, 32'd0);
            checkVal("bp_mant_a", {8'd0, mant_a}, 32'hC00000);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkVal("bp_release_valid", {31'd0, out_valid}, 32'd0);
        checkVal("bp_release_ready", {31'd0, in_ready}, 32'd1);
        checkVal("bp_no_capture", {8'd0, mant_a}, 32'hC00000);

        // Reset mid-ALIGN with d = 10
        sendOp(32'h44800000, 32'h3F800000, 1'b1, lat);
        checkVal("ra_lat", lat, 32'd11);
        consume("ra_pre");
        op_a        = 32'h44800000;
        op_b        = 32'h3F800000;
        sum_or_mult = 1'b1;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkVal("ra_aligning", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        checkVal("ra_mant_a", {8'd0, mant_a}, 32'd0);
        checkVal("ra_mant_b", {8'd0, mant_b}, 32'd0);
        checkVal("ra_exp", {22'd0, exp_out}, 32'd0);
        checkVal("ra_som", {31'd0, sum_or_mult_out}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hits  = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) hits++;
        end
        checkVal("ra_no_valid", hits, 32'd0);
        checkVal("ra_ready", {31'd0, in_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
